// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: width codes,
// requester IDs and the outstanding-read FSM encoding.
package mem_arbiter_pkg;

  // funct3-style access width codes
  localparam logic [2:0] W_B  = 3'b000;
  localparam logic [2:0] W_H  = 3'b001;
  localparam logic [2:0] W_W  = 3'b010;
  localparam logic [2:0] W_BU = 3'b100;
  localparam logic [2:0] W_HU = 3'b101;

  // Requester IDs, also the bit positions in the one-hot grant vector
  localparam logic RQ_IF = 1'b0;
  localparam logic RQ_LS = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRspIf = 2'd1,
    StRspLs = 2'd2
  } state_e;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin arbiter (IF vs LS) with optional fixed LS priority.
// Produces a one-hot grant; the preference pointer flips only on a conflict.
module mem_rr_arb
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LsPrio = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;
  logic win;
  logic conflict;

  always_comb begin
    conflict = &req_i;
    win      = req_i[RQ_LS] ? RQ_LS : RQ_IF;
    if (conflict) begin
      win = (LsPrio != 0) ? RQ_LS : ptr_q;
    end
    gnt_o = 2'b00;
    if (|req_i) begin
      gnt_o[win] = 1'b1;
    end
    // The loser of a conflict becomes the preferred side next time
    ptr_d = conflict ? ~win : ptr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= RQ_IF;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between instruction fetch and the load/store unit,
// returns registered read data to the issuing side and counts contention cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned LS_PRIO = 0,
  parameter int unsigned CW      = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_ls_req,
  input  logic          i_ls_we,
  input  logic [2:0]    i_ls_width,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [DW-1:0] i_ls_wdata,
  output logic          o_ls_gnt,
  output logic          o_ls_rvalid,
  output logic [DW-1:0] o_ls_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic [2:0]    o_mem_width,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_data,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [CW-1:0] o_conflicts
);

  logic [1:0]    req;
  logic [1:0]    gnt;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Requests are masked during reset so no grant or write escapes it
  assign req = {i_ls_req, i_if_req} & {2{~i_rst}};

  mem_rr_arb #(
    .LsPrio (LS_PRIO)
  ) u_arb (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign o_if_gnt = gnt[RQ_IF];
  assign o_ls_gnt = gnt[RQ_LS];

  always_comb begin
    o_mem_addr  = '0;
    o_mem_width = W_W;
    o_mem_we    = 1'b0;
    o_mem_data  = '0;
    if (gnt[RQ_LS]) begin
      o_mem_addr  = i_ls_addr;
      o_mem_width = i_ls_width;
      o_mem_we    = i_ls_we;
      o_mem_data  = i_ls_wdata;
    end else if (gnt[RQ_IF]) begin
      o_mem_addr  = i_if_addr;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (gnt[RQ_IF]) begin
      state_d = StRspIf;
    end else if (gnt[RQ_LS] && !i_ls_we) begin
      state_d = StRspLs;
    end

    cnt_d = cnt_q;
    if (i_if_req && i_ls_req && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_if_rvalid = (state_q == StRspIf);
  assign o_ls_rvalid = (state_q == StRspLs);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
  assign o_conflicts = cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (round-robin/CW=16, LS-priority/CW=4)
// each with a registered memory model; read responses checked via a scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_width;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;

  logic        d0_if_gnt, d0_if_rvalid, d0_ls_gnt, d0_ls_rvalid, d0_mem_we;
  logic [31:0] d0_if_rdata, d0_ls_rdata, d0_mem_addr, d0_mem_data, mem0_rdata;
  logic [2:0]  d0_mem_width;
  logic [15:0] d0_conflicts;

  logic        d1_if_gnt, d1_if_rvalid, d1_ls_gnt, d1_ls_rvalid, d1_mem_we;
  logic [31:0] d1_if_rdata, d1_ls_rdata, d1_mem_addr, d1_mem_data, mem1_rdata;
  logic [2:0]  d1_mem_width;
  logic [3:0]  d1_conflicts;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;

  typedef struct packed {
    logic        side;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  logic sel;
  logic mon_en;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .LS_PRIO(0), .CW(16)) dut0 (
    .i_clk (clk), .i_rst (rst),
    .i_if_req (if_req), .i_if_addr (if_addr),
    .o_if_gnt (d0_if_gnt), .o_if_rvalid (d0_if_rvalid), .o_if_rdata (d0_if_rdata),
    .i_ls_req (ls_req), .i_ls_we (ls_we), .i_ls_width (ls_width),
    .i_ls_addr (ls_addr), .i_ls_wdata (ls_wdata),
    .o_ls_gnt (d0_ls_gnt), .o_ls_rvalid (d0_ls_rvalid), .o_ls_rdata (d0_ls_rdata),
    .o_mem_addr (d0_mem_addr), .o_mem_width (d0_mem_width), .o_mem_we (d0_mem_we),
    .o_mem_data (d0_mem_data), .i_mem_rdata (mem0_rdata), .o_conflicts (d0_conflicts)
  );

  mem_arbiter #(.AW(32), .DW(32), .LS_PRIO(1), .CW(4)) dut1 (
    .i_clk (clk), .i_rst (rst),
    .i_if_req (if_req), .i_if_addr (if_addr),
    .o_if_gnt (d1_if_gnt), .o_if_rvalid (d1_if_rvalid), .o_if_rdata (d1_if_rdata),
    .i_ls_req (ls_req), .i_ls_we (ls_we), .i_ls_width (ls_width),
    .i_ls_addr (ls_addr), .i_ls_wdata (ls_wdata),
    .o_ls_gnt (d1_ls_gnt), .o_ls_rvalid (d1_ls_rvalid), .o_ls_rdata (d1_ls_rdata),
    .o_mem_addr (d1_mem_addr), .o_mem_width (d1_mem_width), .o_mem_we (d1_mem_we),
    .o_mem_data (d1_mem_data), .i_mem_rdata (mem1_rdata), .o_conflicts (d1_conflicts)
  );

  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] wd);
    case (wd)
      W_B:     return {{24{w[7]}}, w[7:0]};
      W_H:     return {{16{w[15]}}, w[15:0]};
      W_BU:    return {24'h0, w[7:0]};
      W_HU:    return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [2:0] wd);
    case (wd)
      W_B:     return {old[31:8], d[7:0]};
      W_H:     return {old[31:16], d[15:0]};
      default: return d;
    endcase
  endfunction

  // Registered single-port memory models
  always @(posedge clk) begin
    if (pl_en) begin
      mem0[pl_addr] <= pl_data;
      mem1[pl_addr] <= pl_data;
    end
    if (d0_mem_we) mem0[d0_mem_addr[3:0]] <= st_merge(mem0[d0_mem_addr[3:0]], d0_mem_data,
                                                      d0_mem_width);
    if (d1_mem_we) mem1[d1_mem_addr[3:0]] <= st_merge(mem1[d1_mem_addr[3:0]], d1_mem_data,
                                                      d1_mem_width);
    mem0_rdata <= ld_ext(mem0[d0_mem_addr[3:0]], d0_mem_width);
    mem1_rdata <= ld_ext(mem1[d1_mem_addr[3:0]], d1_mem_width);
  end

  // Response monitor: pops the scoreboard on every rvalid of the selected DUT
  always @(negedge clk) begin
    logic        rv_if, rv_ls;
    logic [31:0] rd_if, rd_ls;
    exp_t        e;
    #2;
    if (mon_en) begin
      rv_if = sel ? d1_if_rvalid : d0_if_rvalid;
      rv_ls = sel ? d1_ls_rvalid : d0_ls_rvalid;
      rd_if = sel ? d1_if_rdata : d0_if_rdata;
      rd_ls = sel ? d1_ls_rdata : d0_ls_rdata;
      if (rv_if || rv_ls) begin
        checks++;
        if (rv_if && rv_ls) begin
          errors++;
          $display("FAIL rsp_both: if_rvalid=%0b ls_rvalid=%0b, required one at most",
                   rv_if, rv_ls);
        end else if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: if_rvalid=%0b ls_rvalid=%0b, required none at %0t",
                   rv_if, rv_ls, $time);
        end else begin
          e = sb.pop_front();
          if (rv_ls !== e.side || (rv_ls ? rd_ls : rd_if) !== e.data) begin
            errors++;
            $display("FAIL rsp_data: side=%0b data=%h, required side=%0b data=%h",
                     rv_ls, rv_ls ? rd_ls : rd_if, e.side, e.data);
          end
        end
      end
      checks++;
      if ((!rv_if && rd_if !== 32'h0) || (!rv_ls && rd_ls !== 32'h0)) begin
        errors++;
        $display("FAIL rdata_idle: if_rdata=%h ls_rdata=%h, required 0 when not valid",
                 rd_if, rd_ls);
      end
    end
  end

  task automatic idle_inputs();
    if_req   = 1'b0;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_we    = 1'b0;
    ls_width = W_W;
    ls_addr  = '0;
    ls_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload();
    logic [3:0]  pa [7];
    logic [31:0] pd [7];
    pa = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9};
    pd = '{32'h11111111, 32'h22222222, 32'h44444444, 32'hDEADBEEF,
           32'h66666666, 32'h0000F00D, 32'hA5A5A5A5};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pl_en = 1'b1;
      pl_addr = pa[i];
      pl_data = pd[i];
    end
    @(negedge clk);
    pl_en = 1'b1;
    pl_addr = 4'd10;
    pl_data = 32'hCAFEF00D;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'd5;
    #1;
    checks++;
    if (d0_if_gnt !== 1'b0 || d0_ls_gnt !== 1'b0 || d0_if_rvalid !== 1'b0 ||
        d0_ls_rvalid !== 1'b0 || d0_if_rdata !== 32'h0 || d0_ls_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_hs: gnt=%b%b rvalid=%b%b rdata=%h/%h, required all 0",
               d0_if_gnt, d0_ls_gnt, d0_if_rvalid, d0_ls_rvalid, d0_if_rdata, d0_ls_rdata);
    end
    checks++;
    if (d0_conflicts !== 16'h0 || d0_mem_we !== 1'b0 || d0_mem_addr !== 32'h0 ||
        d0_mem_width !== W_W || d0_mem_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: conf=%0d we=%b addr=%h w=%b data=%h, required 0/0/0/010/0",
               d0_conflicts, d0_mem_we, d0_mem_addr, d0_mem_width, d0_mem_data);
    end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_if_alone();
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'd5;
    #1;
    checks++;
    if (d0_if_gnt !== 1'b1 || d0_ls_gnt !== 1'b0 || d0_mem_addr !== 32'd5 ||
        d0_mem_width !== W_W || d0_mem_we !== 1'b0) begin
      errors++;
      $display("FAIL if_alone_gnt: gnt=%b%b addr=%h w=%b we=%b, required 10/5/010/0",
               d0_if_gnt, d0_ls_gnt, d0_mem_addr, d0_mem_width, d0_mem_we);
    end
    #2;
    sb.push_back('{side: RQ_IF, data: 32'hDEADBEEF});
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (d0_if_rvalid !== 1'b1 || d0_ls_rvalid !== 1'b0 || d0_if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL if_alone_rsp: if_rvalid=%b ls_rvalid=%b if_gnt=%b, required 1/0/0",
               d0_if_rvalid, d0_ls_rvalid, d0_if_gnt);
    end
    #2;
    @(negedge clk);
    #1;
    checks++;
    if (d0_mem_we !== 1'b0 || d0_mem_addr !== 32'h0 || d0_mem_width !== W_W ||
        d0_mem_data !== 32'h0 || d0_if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL no_grant: we=%b addr=%h w=%b data=%h rvalid=%b, required 0/0/010/0/0",
               d0_mem_we, d0_mem_addr, d0_mem_width, d0_mem_data, d0_if_rvalid);
    end
  endtask

  task automatic test_store_load();
    logic [2:0]  lw [3];
    logic [31:0] la [3];
    logic [31:0] le [3];
    lw = '{W_B, W_H, W_HU};
    la = '{32'd3, 32'd7, 32'd7};
    le = '{32'h00000078, 32'hFFFFF00D, 32'h0000F00D};
    @(negedge clk);
    ls_req = 1'b1;
    ls_we = 1'b1;
    ls_width = W_W;
    ls_addr = 32'd3;
    ls_wdata = 32'h12345678;
    #1;
    checks++;
    if (d0_ls_gnt !== 1'b1 || d0_mem_we !== 1'b1 || d0_mem_addr !== 32'd3 ||
        d0_mem_data !== 32'h12345678 || d0_mem_width !== W_W) begin
      errors++;
      $display("FAIL store_gnt: gnt=%b we=%b addr=%h data=%h w=%b, required 1/1/3/12345678/010",
               d0_ls_gnt, d0_mem_we, d0_mem_addr, d0_mem_data, d0_mem_width);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ls_we = 1'b0;
      ls_width = lw[i];
      ls_addr = la[i];
      ls_wdata = '0;
      #1;
      checks++;
      if (d0_ls_gnt !== 1'b1 || d0_mem_we !== 1'b0 || d0_mem_width !== lw[i]) begin
        errors++;
        $display("FAIL load_gnt%0d: gnt=%b we=%b w=%b, required 1/0/%b",
                 i, d0_ls_gnt, d0_mem_we, d0_mem_width, lw[i]);
      end
      #2;
      sb.push_back('{side: RQ_LS, data: le[i]});
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_conflict_rr();
    logic [3:0] exp_if;
    exp_if = 4'b0101;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_req = 1'b1;
      if_addr = 32'd1;
      ls_req = 1'b1;
      ls_we = 1'b0;
      ls_width = W_W;
      ls_addr = 32'd2;
      #1;
      checks++;
      if (d0_if_gnt !== exp_if[i] || d0_ls_gnt !== ~exp_if[i]) begin
        errors++;
        $display("FAIL rr_gnt%0d: if_gnt=%b ls_gnt=%b, required %b/%b",
                 i, d0_if_gnt, d0_ls_gnt, exp_if[i], ~exp_if[i]);
      end
      #2;
      if (exp_if[i]) sb.push_back('{side: RQ_IF, data: 32'h11111111});
      else           sb.push_back('{side: RQ_LS, data: 32'h22222222});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (d0_conflicts !== 16'd4) begin
      errors++;
      $display("FAIL rr_conflicts: o_conflicts=%0d, required 4", d0_conflicts);
    end
    @(negedge clk);
  endtask

  task automatic test_drop();
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'd1;
    ls_req = 1'b1;
    ls_we = 1'b1;
    ls_addr = 32'd4;
    ls_wdata = 32'hBADBAD00;
    #1;
    checks++;
    if (d0_if_gnt !== 1'b1 || d0_ls_gnt !== 1'b0 || d0_mem_we !== 1'b0) begin
      errors++;
      $display("FAIL drop_gnt: if_gnt=%b ls_gnt=%b we=%b, required 1/0/0",
               d0_if_gnt, d0_ls_gnt, d0_mem_we);
    end
    #2;
    sb.push_back('{side: RQ_IF, data: 32'h11111111});
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    ls_req = 1'b1;
    ls_addr = 32'd4;
    #3;
    sb.push_back('{side: RQ_LS, data: 32'h44444444});
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'd5;
    #1;
    checks++;
    if (d0_if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midrst_gnt: if_gnt=%b, required 1", d0_if_gnt);
    end
    #2;
    rst = 1'b1;
    ls_req = 1'b1;
    ls_we = 1'b1;
    ls_addr = 32'd6;
    ls_wdata = 32'h0BAD0BAD;
    #1;
    checks++;
    if (d0_if_gnt !== 1'b0 || d0_ls_gnt !== 1'b0 || d0_mem_we !== 1'b0 ||
        d0_conflicts !== 16'h0) begin
      errors++;
      $display("FAIL midrst_out: gnt=%b%b we=%b conf=%0d, required 0/0/0/0",
               d0_if_gnt, d0_ls_gnt, d0_mem_we, d0_conflicts);
    end
    @(negedge clk);
    #1;
    checks++;
    if (d0_if_rvalid !== 1'b0 || d0_if_rdata !== 32'h0 || d0_mem_we !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rsp: if_rvalid=%b rdata=%h we=%b, required 0/0/0",
               d0_if_rvalid, d0_if_rdata, d0_mem_we);
    end
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'd5;
    #1;
    checks++;
    if (d0_if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL postrst_gnt: if_gnt=%b, required 1", d0_if_gnt);
    end
    #2;
    sb.push_back('{side: RQ_IF, data: 32'hDEADBEEF});
    @(negedge clk);
    idle_inputs();
    ls_req = 1'b1;
    ls_addr = 32'd6;
    #3;
    sb.push_back('{side: RQ_LS, data: 32'h66666666});
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_fixed_prio();
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if_req = 1'b1;
      if_addr = 32'd9;
      ls_req = (i < 3);
      ls_we = 1'b0;
      ls_width = W_W;
      ls_addr = 32'd10;
      #1;
      checks++;
      if (d1_ls_gnt !== (i < 3) || d1_if_gnt !== (i == 3)) begin
        errors++;
        $display("FAIL prio_gnt%0d: if_gnt=%b ls_gnt=%b, required %b/%b",
                 i, d1_if_gnt, d1_ls_gnt, (i == 3), (i < 3));
      end
      #2;
      if (i < 3) sb.push_back('{side: RQ_LS, data: 32'hCAFEF00D});
      else       sb.push_back('{side: RQ_IF, data: 32'hA5A5A5A5});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (d1_conflicts !== 4'd3) begin
      errors++;
      $display("FAIL prio_conflicts: o_conflicts=%0d, required 3", d1_conflicts);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if_req = 1'b1;
      if_addr = 32'd9;
      ls_req = 1'b1;
      ls_we = 1'b1;
      ls_width = W_W;
      ls_addr = 32'd11;
      ls_wdata = 32'(i);
      #1;
      if (i == 10) begin
        checks++;
        if (d1_conflicts !== 4'd13) begin
          errors++;
          $display("FAIL sat_mid: o_conflicts=%0d, required 13", d1_conflicts);
        end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (d1_conflicts !== 4'd15) begin
      errors++;
      $display("FAIL sat_final: o_conflicts=%0d, required 15", d1_conflicts);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    mon_en = 1'b0;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    idle_inputs();
    preload();
    test_reset();
    test_if_alone();
    test_store_load();
    test_conflict_rr();
    test_drop();
    test_reset_mid_read();
    test_fixed_prio();
    test_saturation();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
